// File: rtl/code_lock_seq.sv
// code_lock_seq: sequential keypad code lock with error budget, lockout and seven-segment status.
// Digits are accepted on rising edges of insere and compared one by one against CODE.
// Optional build macro CODE_LOCK_TIMEOUT_EN adds an inactivity timeout while in ENTRY.
module code_lock_seq #(
  parameter int unsigned               CODE_LEN       = 6,
  parameter logic [4*CODE_LEN-1:0]     CODE           = 24'h589204,
  parameter int unsigned               MAX_ERRORS     = 1,
  parameter int unsigned               LOCKOUT_CYCLES = 16,
  parameter int unsigned               TIMEOUT_CYCLES = 1000,
  localparam int unsigned              PosW           = $clog2(CODE_LEN + 1),
  localparam int unsigned              ErrW           = $clog2(MAX_ERRORS + 2)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            insere,
  input  logic [3:0]      numero,
  input  logic            limpa,
  output logic [2:0]      estado,
  output logic [PosW-1:0] posicao,
  output logic [ErrW-1:0] erros,
  output logic [6:0]      display,
  output logic            led
);

  localparam int unsigned LockW    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int unsigned LockLoad = (LOCKOUT_CYCLES == 0) ? 0 : LOCKOUT_CYCLES - 1;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StEntry     = 3'd1,
    StOkFull    = 3'd2,
    StOkPartial = 3'd3,
    StFail      = 3'd4
  } state_e;

  localparam logic [6:0] SegZero = 7'b0000001;
  localparam logic [6:0] SegS    = 7'b0100100;
  localparam logic [6:0] SegP    = 7'b0011000;
  localparam logic [6:0] SegF    = 7'b0111000;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000010;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  state_e            state_q, state_d;
  logic [PosW-1:0]   pos_q, pos_d;
  logic [ErrW-1:0]   err_q, err_d;
  logic [6:0]        disp_q, disp_d;
  logic              led_q, led_d;
  logic              insere_q, insere_d;
  logic [LockW-1:0]  lock_q, lock_d;

  logic              strobe;
  logic              digit_taken;
  logic              tmo_hit;
  logic [3:0]        code_digit;
  logic [PosW-1:0]   pos_inc;
  logic [ErrW-1:0]   err_inc;

`ifdef CODE_LOCK_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [TmoW-1:0] tmo_q, tmo_d;

  // Inactivity counter: counts cycles in ENTRY since the last valid digit.
  always_comb begin
    tmo_d = '0;
    if (state_q == StEntry && !strobe) tmo_d = tmo_q + 1'b1;
  end

  assign tmo_hit = (state_q == StEntry) && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  // Inactivity counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  // Parameter kept for a uniform interface; it has no effect without the timeout build.
  assign tmo_hit = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

  assign strobe  = insere & ~insere_q & (numero <= 4'd9);
  assign pos_inc = pos_q + 1'b1;
  assign err_inc = err_q + 1'b1;

  // Expected digit at the current match position (constant-select mux, no variable slicing).
  always_comb begin
    code_digit = '0;
    for (int unsigned i = 0; i < CODE_LEN; i++) begin
      if (pos_q == PosW'(i)) code_digit = CODE[4*(CODE_LEN-1-i) +: 4];
    end
  end

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    err_d       = err_q;
    lock_d      = lock_q;
    insere_d    = insere;
    digit_taken = 1'b0;

    unique case (state_q)
      StIdle, StEntry: begin
        if (limpa) begin
          state_d = StIdle;
          pos_d   = '0;
          err_d   = '0;
        end else if (strobe) begin
          digit_taken = 1'b1;
          if (numero == code_digit) begin
            pos_d = pos_inc;
            if (pos_inc == PosW'(CODE_LEN)) begin
              state_d = (err_q == '0) ? StOkFull : StOkPartial;
            end else begin
              state_d = StEntry;
            end
          end else begin
            // Wrong digit: position holds so the same digit is retried.
            err_d = err_inc;
            if (err_inc > ErrW'(MAX_ERRORS)) begin
              state_d = StFail;
              lock_d  = LockW'(LockLoad);
            end else begin
              state_d = StEntry;
            end
          end
        end else if (tmo_hit) begin
          state_d = StIdle;
          pos_d   = '0;
          err_d   = '0;
        end
      end
      StOkFull, StOkPartial: begin
        if (limpa) begin
          state_d = StIdle;
          pos_d   = '0;
          err_d   = '0;
        end
      end
      StFail: begin
        // LOCKOUT_CYCLES == 0 keeps the lock failed until reset.
        if (LOCKOUT_CYCLES != 0) begin
          if (lock_q == '0) begin
            state_d = StIdle;
            pos_d   = '0;
            err_d   = '0;
          end else begin
            lock_d = lock_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        pos_d   = '0;
        err_d   = '0;
      end
    endcase

    unique case (state_d)
      StIdle:      disp_d = SegZero;
      StEntry:     disp_d = digit_taken ? seg7(numero) : disp_q;
      StOkFull:    disp_d = SegS;
      StOkPartial: disp_d = SegP;
      StFail:      disp_d = SegF;
      default:     disp_d = SegZero;
    endcase

    led_d = (err_d != '0) && (state_d == StEntry || state_d == StFail);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      pos_q    <= '0;
      err_q    <= '0;
      disp_q   <= SegZero;
      led_q    <= 1'b0;
      insere_q <= 1'b0;
      lock_q   <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      err_q    <= err_d;
      disp_q   <= disp_d;
      led_q    <= led_d;
      insere_q <= insere_d;
      lock_q   <= lock_d;
    end
  end

  assign estado  = state_q;
  assign posicao = pos_q;
  assign erros   = err_q;
  assign display = disp_q;
  assign led     = led_q;

endmodule

// File: tb/tb_code_lock_seq.sv
// Self-checking bench for code_lock_seq: directed test-plan steps plus random stimulus,
// all compared against an event-level reference model of the lock's rules.
module tb_code_lock_seq;

  localparam int LOCK = 16;
  localparam int MAXE = 1;
  localparam int TMO  = 20;
  localparam int CLEN = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       insere;
  logic [3:0] numero;
  logic       limpa;
  logic [2:0] estado;
  logic [2:0] posicao;
  logic [1:0] erros;
  logic [6:0] display;
  logic       led;

  code_lock_seq #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .insere  (insere),
    .numero  (numero),
    .limpa   (limpa),
    .estado  (estado),
    .posicao (posicao),
    .erros   (erros),
    .display (display),
    .led     (led)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: abstract state plus cycle stamps of notable events.
  int code [CLEN] = '{5, 8, 9, 2, 0, 4};
  int cyc = 0;
  int m_state, m_pos, m_err, m_last, m_fail_cyc, m_act;
  bit m_prev;

  function automatic int seg(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000010;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int exp_disp();
    case (m_state)
      0: return 7'b0000001;
      1: return seg(m_last);
      2: return 7'b0100100;
      3: return 7'b0011000;
      default: return 7'b0111000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    total++;
    assert (obs === 32'(exp)) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".estado"}, 32'(estado), m_state);
    chk({tag, ".posicao"}, 32'(posicao), m_pos);
    chk({tag, ".erros"}, 32'(erros), m_err);
    chk({tag, ".display"}, 32'(display), exp_disp());
    chk({tag, ".led"}, 32'(led), int'(m_err != 0 && (m_state == 1 || m_state == 4)));
  endtask

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_err = 0; m_last = 0; m_prev = 1'b0;
  endtask

  task automatic model_clear();
    m_state = 0; m_pos = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit stb;
    cyc++;
    stb    = insere && !m_prev && (numero <= 9);
    m_prev = insere;
    case (m_state)
      4: if (LOCK != 0 && cyc - m_fail_cyc == LOCK) model_clear();
      2, 3: if (limpa) model_clear();
      default: begin
        if (limpa) model_clear();
        else if (stb) begin
          m_last = int'(numero);
          m_act  = cyc;
          if (int'(numero) == code[m_pos]) begin
            m_pos++;
            if (m_pos == CLEN) m_state = (m_err == 0) ? 2 : 3;
            else m_state = 1;
          end else begin
            m_err++;
            if (m_err > MAXE) begin
              m_state    = 4;
              m_fail_cyc = cyc;
            end else m_state = 1;
          end
        end
`ifdef CODE_LOCK_TIMEOUT_EN
        else if (m_state == 1 && cyc - m_act == TMO) model_clear();
`endif
      end
    endcase
  endtask

  // One clock: model advances with the inputs the DUT samples, then all outputs are compared.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    chk_all(tag);
  endtask

  task automatic strobe(input int d);
    insere = 1'b1; numero = 4'(d);
    tick("strobe_hi");
    insere = 1'b0;
    tick("strobe_lo");
  endtask

  initial begin
    int n;
    reset = 1'b1; insere = 1'b0; numero = 4'd0; limpa = 1'b0;
    model_reset();
    #1;
    chk_all("reset");
    chk("reset.display_const", 32'(display), 7'b0000001);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Full success.
    foreach (code[i]) strobe(code[i]);
    chk("full.estado", 32'(estado), 2);
    chk("full.display", 32'(display), 7'b0100100);
    chk("full.erros", 32'(erros), 0);
    chk("full.led", 32'(led), 0);
    limpa = 1'b1; tick("clr1"); limpa = 1'b0;

    // Partial success after one tolerated error.
    strobe(5); strobe(3);
    chk("part.erros", 32'(erros), 1);
    chk("part.led", 32'(led), 1);
    chk("part.posicao", 32'(posicao), 1);
    strobe(8); strobe(9); strobe(2); strobe(0); strobe(4);
    chk("part.estado", 32'(estado), 3);
    chk("part.display", 32'(display), 7'b0011000);
    limpa = 1'b1; tick("clr2"); limpa = 1'b0;

    // Failure and timed lockout; digits strobed during FAIL are ignored.
    strobe(1);
    insere = 1'b1; numero = 4'd1; tick("fail_entry");
    chk("fail.estado", 32'(estado), 4);
    chk("fail.led", 32'(led), 1);
    n = 0;
    numero = 4'd5;
    while (estado == 3'd4 && n < 100) begin
      n++;
      insere = ~insere;
      tick("fail_dwell");
    end
    insere = 1'b0;
    chk("fail.dwell", 32'(n), LOCK);
    chk("fail.exit_estado", 32'(estado), 0);
    chk("fail.exit_erros", 32'(erros), 0);
    tick("post_fail");

    // Held strobe gives one acceptance; invalid digit changes nothing.
    insere = 1'b1; numero = 4'd5;
    repeat (5) tick("hold");
    insere = 1'b0; tick("hold_lo");
    chk("hold.posicao", 32'(posicao), 1);
    insere = 1'b1; numero = 4'd12; tick("inv_hi");
    chk("inv.estado", 32'(estado), 1);
    chk("inv.posicao", 32'(posicao), 1);
    chk("inv.display", 32'(display), 7'b0100100);
    insere = 1'b0; tick("inv_lo");

    // limpa wins over a simultaneous strobe.
    limpa = 1'b1; insere = 1'b1; numero = 4'd8; tick("limpa_stb");
    chk("limpa.estado", 32'(estado), 0);
    chk("limpa.posicao", 32'(posicao), 0);
    limpa = 1'b0; insere = 1'b0; tick("limpa_lo");

    // Asynchronous reset in the middle of a lockout.
    strobe(1); strobe(1);
    repeat (3) tick("lock_mid");
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("arst.estado", 32'(estado), 0);
    chk_all("arst");
    #1 reset = 1'b0;
    tick("arst_post");

    // Inactivity in ENTRY.
    strobe(5);
    repeat (TMO - 1) tick("tmo_wait");
`ifdef CODE_LOCK_TIMEOUT_EN
    chk("tmo.estado", 32'(estado), 0);
`else
    chk("tmo.estado", 32'(estado), 1);
`endif
    limpa = 1'b1; tick("clr3"); limpa = 1'b0;

    // Random stimulus biased toward the expected digit so success paths are reached.
    for (int k = 0; k < 3000; k++) begin
      insere = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 6 && m_pos < CLEN) numero = 4'(code[m_pos]);
      else numero = 4'($urandom_range(0, 15));
      limpa = ($urandom_range(0, 19) == 0);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/code_lock_seq.md
# code_lock_seq

Parametrised sequential code-lock controller for the keypad/seven-segment lock subsystem.
- Accepts BCD digits one per `insere` rising edge and compares them against a compile-time code of configurable length.
- Tolerates up to `MAX_ERRORS` wrong digits, then reports full success, partial success or failure on a seven-segment output.
- Generalises the fixed 6-digit, 1-error lock with configurable code/length/error budget, edge-detected entry, a `limpa` clear input and timed lockout recovery.

## Interface
- `CODE_LEN`, 6, number of digits in the code (1..15).
- `CODE`, 24'h589204, packed code, 4 bits per digit; digit 0 in the most-significant nibble, `CODE[4*(CODE_LEN-1-i) +: 4]` = digit i.
- `MAX_ERRORS`, 1, wrong digits tolerated (0..7).
- `LOCKOUT_CYCLES`, 16, cycles spent in FAIL before auto-return to IDLE; 0 = FAIL held until reset.
- `TIMEOUT_CYCLES`, 1000, inactivity limit in ENTRY (used only with `CODE_LOCK_TIMEOUT_EN`).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `insere` in 1: digit strobe (level); one digit accepted per 0→1 transition.
- `numero` in 4: BCD digit; values 10..15 are invalid.
- `limpa` in 1: synchronous clear request.
- `estado` out 3: IDLE=0, ENTRY=1, OK_FULL=2, OK_PARTIAL=3, FAIL=4.
- `posicao` out clog2(CODE_LEN+1): correct digits matched so far.
- `erros` out clog2(MAX_ERRORS+2): wrong digits so far.
- `display` out 7: seven-segment pattern {a..g}, active-low.
- `led` out 1: error indicator.

## Operation
- Edge detect: `insere_q` is registered `insere` (reset 0). Strobe = `insere & ~insere_q`. A valid strobe also requires `numero <= 9`; invalid digits are ignored and change no state.
- IDLE/ENTRY, on a valid strobe with digit d, target t = code digit at index `posicao`:
  - d == t: `posicao`+1. If the new value equals CODE_LEN, go to OK_FULL when `erros`==0, otherwise OK_PARTIAL. Else go to ENTRY.
  - d != t: `posicao` unchanged, so the same digit is retried. `erros`+1. If the new value exceeds MAX_ERRORS, go to FAIL, else go to ENTRY.
- OK_FULL and OK_PARTIAL hold, ignore digits, and leave only on `limpa` or reset.
- FAIL:
  - On entry, the lockout counter loads LOCKOUT_CYCLES-1 and decrements every cycle.
  - When the counter is 0, next state is IDLE with `posicao` and `erros` cleared.
  - Digits and `limpa` are ignored in FAIL.
  - LOCKOUT_CYCLES=0 means FAIL is held until reset.
- `limpa` in IDLE/ENTRY/OK_*: next state IDLE, counters cleared. `limpa` has priority over a simultaneous strobe.
- `display`, registered:
  - IDLE 7'b0000001 ('0'), OK_FULL 7'b0100100 ('S'), OK_PARTIAL 7'b0011000 ('P'), FAIL 7'b0111000 ('F').
  - ENTRY shows the last accepted digit with the standard map: 0→0000001, 1→1001111, 2→0010010, 3→0000110, 4→1001100, 5→0100100, 6→0100000, 7→0001111, 8→0000000, 9→0000010.
- `led` = 1 while `erros` != 0 and `estado` is ENTRY or FAIL, else 0.

## Timing
- All outputs are registered and update on the rising `clk` edge at which the strobe is seen. The first digit is therefore visible one cycle after `insere` rises relative to the sampled edge, with no extra latency.
- A level held high on `insere` produces exactly one acceptance. The next acceptance requires `insere` to go low for at least one cycle.
- FAIL dwell is exactly LOCKOUT_CYCLES cycles from the first cycle `estado`==4 to the first cycle `estado`==0.
- Reset values: `estado`=0, `posicao`=0, `erros`=0, `led`=0, `display`=7'b0000001, `insere_q`=0, lockout/timeout counters 0.
- Reset mid-sequence, including during lockout, returns to IDLE immediately and asynchronously.

## Configuration
- `CODE_LOCK_TIMEOUT_EN` defined:
  - An inactivity counter runs in ENTRY and reloads on every valid strobe.
  - After TIMEOUT_CYCLES cycles without a valid strobe, next state is IDLE with counters cleared.
  - Counter is idle in other states.
- Not defined: no timeout logic; ENTRY persists indefinitely and TIMEOUT_CYCLES is unused.

## Test plan
- Defaults, strobes 5,8,9,2,0,4 → `estado`=2, `display`=7'b0100100, `erros`=0, `led`=0.
- Strobes 5,3,8,9,2,0,4 → after 3: `erros`=1, `led`=1, `posicao`=1; final `estado`=3, `display`=7'b0011000.
- Strobes 1,1 → `estado`=4 after the second; `led`=1; exactly 16 cycles later `estado`=0, `erros`=0; digits strobed during FAIL ignored.
- `insere` held high 5 cycles with `numero`=5, plus `numero`=12 strobed → only one acceptance (`posicao`=1); invalid digit leaves all outputs unchanged.
- `limpa` and a strobe in the same cycle from ENTRY → `estado`=0, `posicao`=0; `reset` pulsed mid-lockout → IDLE at once.
- With `CODE_LOCK_TIMEOUT_EN`, TIMEOUT_CYCLES=20: strobe 5, then idle 20 cycles → `estado`=0; without the macro → `estado` stays 1.
